// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - shared state encodings and default parameters
// Purpose: FSM state type, default parameter values and the hold counter
//          width helper used by the pulse stretcher files.
// Ports:   none (package).
package pulse_stretcher_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_e;

   localparam int DEF_WIDTH_W = 8;
   localparam int DEF_HOLDOFF = 4;
   localparam int DEF_DROP_W  = 8;

   // Hold counter needs $clog2(HOLDOFF+1) bits, but never fewer than one.
   function automatic int hold_cnt_w(input int holdoff);
      return (holdoff > 0) ? $clog2(holdoff + 1) : 1;
   endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// rtl/pulse_stretcher_if.sv - trigger/width/pulse bundle of the pulse stretcher
// Purpose: groups the event input, width setting and stretched outputs.
// Signals: trig_in (event pulse), width (pulse length), out (stretched
//          pulse), busy (ACTIVE or HOLDOFF), drop_cnt (rejected triggers).
// Modports: master drives trig_in/width, slave drives out/busy/drop_cnt.
interface pulse_stretcher_if
   import pulse_stretcher_pkg::*;
#(
   parameter int WIDTH_W = DEF_WIDTH_W,
   parameter int DROP_W  = DEF_DROP_W
);

   logic               trig_in;
   logic [WIDTH_W-1:0] width;
   logic               out;
   logic               busy;
   logic [DROP_W-1:0]  drop_cnt;

   modport master (
      output trig_in, width,
      input  out, busy, drop_cnt
   );

   modport slave (
      input  trig_in, width,
      output out, busy, drop_cnt
   );

endinterface

// File: rtl/pulse_stretcher_sat_counter.sv
// rtl/pulse_stretcher_sat_counter.sv - saturating up counter with synchronous clear
// Purpose: counts inc pulses and holds at all-ones; clr has priority.
// Ports:   clk, clr (sync clear), inc (count enable), value (N-bit count).
module sat_counter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [N-1:0] value
);

   logic [N-1:0] value_q;
   logic [N-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (inc && (value_q != '1)) begin
         value_d = value_q + N'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches single-cycle triggers into programmable pulses
// Purpose: each accepted trigger produces a registered pulse of width cycles
//          (0 treated as 1) followed by HOLDOFF guard cycles; triggers that
//          are not accepted are counted in a saturating drop counter.
// Ports:   clk, rst (synchronous, active high), ps (pulse_stretcher_if.slave:
//          trig_in, width in; out, busy, drop_cnt out).
// Config:  PSTRETCH_RETRIGGER_EN - a trigger during ACTIVE reloads the
//          active counter instead of being dropped.
module pulse_stretcher
   import pulse_stretcher_pkg::*;
#(
   parameter int WIDTH_W = DEF_WIDTH_W,
   parameter int HOLDOFF = DEF_HOLDOFF,
   parameter int DROP_W  = DEF_DROP_W
) (
   input  logic              clk,
   input  logic              rst,
   pulse_stretcher_if.slave  ps
);

   localparam int               HC_W   = hold_cnt_w(HOLDOFF);
   localparam logic [HC_W-1:0]  HOLD_V = HC_W'(HOLDOFF);

   state_e             state_q, state_d;
   logic [WIDTH_W-1:0] act_cnt_q, act_cnt_d;
   logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic               out_q, out_d;
   logic               busy_q, busy_d;
   logic               drop_inc;
   logic [WIDTH_W-1:0] act_load;

   assign act_load = (ps.width == '0) ? WIDTH_W'(1) : ps.width;

   always_comb begin
      state_d    = state_q;
      act_cnt_d  = act_cnt_q;
      hold_cnt_d = hold_cnt_q;
      out_d      = out_q;
      busy_d     = busy_q;
      drop_inc   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            out_d  = 1'b0;
            busy_d = 1'b0;
            if (ps.trig_in) begin
               state_d   = ST_ACTIVE;
               act_cnt_d = act_load;
               out_d     = 1'b1;
               busy_d    = 1'b1;
            end
         end

         ST_ACTIVE: begin
            out_d  = 1'b1;
            busy_d = 1'b1;
`ifdef PSTRETCH_RETRIGGER_EN
            // Reload takes priority over ending the pulse, so out never dips.
            if (ps.trig_in) begin
               act_cnt_d = act_load;
            end else
`else
            drop_inc = ps.trig_in;
`endif
            if (act_cnt_q == WIDTH_W'(1)) begin
               if (HOLDOFF > 0) begin
                  state_d    = ST_HOLDOFF;
                  hold_cnt_d = HOLD_V;
                  out_d      = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  out_d   = 1'b0;
                  busy_d  = 1'b0;
               end
            end else begin
               act_cnt_d = act_cnt_q - WIDTH_W'(1);
            end
         end

         ST_HOLDOFF: begin
            out_d    = 1'b0;
            busy_d   = 1'b1;
            drop_inc = ps.trig_in;
            if (hold_cnt_q == HC_W'(1)) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               hold_cnt_d = hold_cnt_q - HC_W'(1);
            end
         end

         default: begin
            // Unused encoding: fall back to IDLE, trigger treated as rejected.
            state_d  = ST_IDLE;
            out_d    = 1'b0;
            busy_d   = 1'b0;
            drop_inc = ps.trig_in;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         act_cnt_q  <= '0;
         hold_cnt_q <= '0;
         out_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         act_cnt_q  <= act_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         out_q      <= out_d;
         busy_q     <= busy_d;
      end
   end

   // rst clears the counter and wins over a simultaneous rejected trigger.
   sat_counter #(
      .N (DROP_W)
   ) u_drop_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (drop_inc),
      .value (ps.drop_cnt)
   );

   assign ps.out  = out_q;
   assign ps.busy = busy_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - directed self-checking bench for pulse_stretcher
module tb_pulse_stretcher;
   import pulse_stretcher_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pulse_stretcher_if #(.WIDTH_W(8), .DROP_W(2)) ps_if ();

   pulse_stretcher #(
      .WIDTH_W (8),
      .HOLDOFF (4),
      .DROP_W  (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ps  (ps_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One active edge, then settle at the falling edge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [31:0] ov;
   logic [31:0] bv;
   logic [31:0] exp_drop;
   logic [31:0] exp_seq [0:4];

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      ps_if.trig_in = 1'b0;
      ps_if.width   = 8'd5;
      @(negedge clk);
      tick();
      rst = 1'b0;
      chk("reset_out", ps_if.out, 0);
      chk("reset_busy", ps_if.busy, 0);
      chk("reset_drop", ps_if.drop_cnt, 0);

      // 1: width 5 -> out s1..s5, busy s1..s9, idle s10
      ov = '0; bv = '0;
      for (int c = 0; c < 12; c++) begin
         ps_if.trig_in = (c == 0);
         tick();
         ov[c+1] = ps_if.out;
         bv[c+1] = ps_if.busy;
      end
      chk("t1_out", ov, 32'h0000_003E);
      chk("t1_busy", bv, 32'h0000_03FE);
      chk("t1_drop", ps_if.drop_cnt, 0);

      // 2: width 0 -> one-cycle pulse
      ps_if.width = 8'd0;
      ov = '0; bv = '0;
      for (int c = 0; c < 8; c++) begin
         ps_if.trig_in = (c == 0);
         tick();
         ov[c+1] = ps_if.out;
         bv[c+1] = ps_if.busy;
      end
      chk("t2_out", ov, 32'h0000_0002);
      chk("t2_busy", bv, 32'h0000_003E);
      chk("t2_drop", ps_if.drop_cnt, 0);

      // 3: width 3, triggers at steps 0 and 2
      ps_if.width = 8'd3;
      ov = '0;
      for (int c = 0; c < 13; c++) begin
         ps_if.trig_in = (c == 0) || (c == 2);
         tick();
         ov[c+1] = ps_if.out;
      end
`ifdef PSTRETCH_RETRIGGER_EN
      chk("t3_out", ov, 32'h0000_003E);
      exp_drop = 0;
`else
      chk("t3_out", ov, 32'h0000_000E);
      exp_drop = 1;
`endif
      chk("t3_drop", ps_if.drop_cnt, exp_drop);

      // 4: width 2; trigger in 2nd HOLDOFF cycle dropped, in first IDLE accepted
      ps_if.width = 8'd2;
      ov = '0; bv = '0;
      for (int c = 0; c < 16; c++) begin
         ps_if.trig_in = (c == 0) || (c == 4) || (c == 7);
         tick();
         ov[c+1] = ps_if.out;
         bv[c+1] = ps_if.busy;
      end
      exp_drop = exp_drop + 1;
      chk("t4_out", ov, 32'h0000_0306);
      chk("t4_busy", bv, 32'h0000_3F7E);
      chk("t4_drop", ps_if.drop_cnt, exp_drop);

      // 5: reset in the 3rd cycle of a width-10 pulse, trig held with rst
      ps_if.width = 8'd10;
      ps_if.trig_in = 1'b1;
      tick();
      chk("t5_out_s1", ps_if.out, 1);
      ps_if.trig_in = 1'b0;
      tick();
      chk("t5_out_s2", ps_if.out, 1);
      rst = 1'b1;
      ps_if.trig_in = 1'b1;
      tick();
      chk("t5_rst_out", ps_if.out, 0);
      chk("t5_rst_busy", ps_if.busy, 0);
      chk("t5_rst_drop", ps_if.drop_cnt, 0);
      rst = 1'b0;
      ps_if.trig_in = 1'b0;
      tick();
      chk("t5_post_out", ps_if.out, 0);
      chk("t5_post_busy", ps_if.busy, 0);
      chk("t5_post_drop", ps_if.drop_cnt, 0);

      // 6: 2-bit drop counter saturates: 1,2,3,3,3 (all drops in HOLDOFF)
      exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 3; exp_seq[4] = 3;
      ps_if.width = 8'd1;
      ps_if.trig_in = 1'b1;
      tick();
      ps_if.trig_in = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         ps_if.trig_in = 1'b1;
         tick();
         chk($sformatf("t6_drop_%0d", k), ps_if.drop_cnt, exp_seq[k]);
      end
      ps_if.trig_in = 1'b0;
      tick();
      chk("t6_idle_busy", ps_if.busy, 0);
      ps_if.trig_in = 1'b1;
      tick();
      chk("t6_accept_out", ps_if.out, 1);
      ps_if.trig_in = 1'b0;
      tick();
      ps_if.trig_in = 1'b1;
      tick();
      chk("t6_drop_4", ps_if.drop_cnt, exp_seq[4]);
      ps_if.trig_in = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      chk("t6_end_busy", ps_if.busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
